// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: format codes, opcodes, FSM states and the immediate range helper
// shared by the encoder and its packer.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_N = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // True when v survives truncation to a signed field of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return hi == '0 || hi == '1;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer; reports format legality and
// whether the immediate is representable in the chosen format.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o,
    output logic        in_range_o
);

    logic shift;

    // SLLI/SRLI/SRAI: funct3 001 or 101 under OP_IMM
    assign shift   = type_i == FMT_I && opcode_i == OP_IMM && funct3_i[1:0] == 2'b01;
    assign legal_o = type_i < FMT_N;

    always_comb begin
        word_o     = '0;
        in_range_o = 1'b1;
        case (type_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                word_o     = shift ? {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i}
                                   : {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                in_range_o = shift ? imm_i[31:5] == '0 : fits_signed(imm_i, 12);
            end
            FMT_S: begin
                word_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                in_range_o = fits_signed(imm_i, 12);
            end
            FMT_B: begin
                word_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
                in_range_o = fits_signed(imm_i, 13) && !imm_i[0];
            end
            FMT_U: begin
                word_o     = {imm_i[31:12], rd_i, opcode_i};
                in_range_o = imm_i[11:0] == '0;
            end
            FMT_J: begin
                word_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                in_range_o = fits_signed(imm_i, 21) && !imm_i[0];
            end
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts RV32I field bundles, packs them and writes the words
// sequentially into instruction memory through a stallable write port.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wr_ready,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              err_range
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, word;
    logic              fin_q, ill_q, rng_q, legal, in_range;

    instr_pack u_pack (
        .type_i     (in_type),
        .opcode_i   (in_opcode),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7_i   (in_funct7),
        .imm_i      (in_imm),
        .word_o     (word),
        .legal_o    (legal),
        .in_range_o (in_range)
    );

    assign addr_d      = addr_q + ADDR_W'(1);
    assign count_d     = count_q + (ADDR_W + 1)'(1);
    assign full        = count_q == {1'b1, {ADDR_W{1'b0}}};
    assign in_ready    = state_q == RUN && !full && !finish;
    assign busy        = state_q != IDLE;
    assign mem_wr_en   = state_q == WRITE;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = wdata_q;
    assign instr_count = count_q;
    assign err_illegal = ill_q;
    assign err_range   = rng_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= BASE;
            mem_addr_q <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            fin_q      <= 1'b0;
            ill_q      <= 1'b0;
            rng_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    addr_q  <= BASE;
                    count_q <= '0;
                    fin_q   <= 1'b0;
                    ill_q   <= 1'b0;
                    rng_q   <= 1'b0;
                end
                RUN: if (finish) begin
                    state_q <= IDLE;
                end else if (in_valid && in_ready) begin
                    if (!legal) ill_q <= 1'b1;
                    else if (!in_range) rng_q <= 1'b1;
                    else begin
                        mem_addr_q <= addr_q;
                        wdata_q    <= word;
                        state_q    <= WRITE;
                    end
                end
                WRITE: if (mem_wr_ready) begin
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    fin_q   <= 1'b0;
                    state_q <= (fin_q || finish) ? IDLE : RUN;
                end else if (finish) begin
                    fin_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed table, stall/finish sequences, randomized bundles
// against a field-arithmetic reference model, and a small wrapping instance.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic        wr;
        logic [31:0] addr, word;
        logic        ill, rng;
        int          cnt;
    } vec_t;

    logic clk = 0, rst = 1, start = 0, finish = 0, in_valid = 0, mem_wr_ready = 0;
    logic [2:0] in_type = 0, in_funct3 = 0;
    logic [6:0] in_opcode = 0, in_funct7 = 0;
    logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [31:0] in_imm = 0;

    logic a_ready, a_wr_en, a_busy, a_full, a_ill, a_rng;
    logic [7:0] a_addr;
    logic [8:0] a_cnt;
    logic [31:0] a_wdata;
    logic b_ready, b_wr_en, b_busy, b_full, b_ill, b_rng;
    logic [1:0] b_addr;
    logic [2:0] b_cnt;
    logic [31:0] b_wdata;

    int vectors = 0, miscompares = 0;
    logic sel = 0;
    logic o_ready, o_wr_en, o_busy, o_full, o_ill, o_rng;
    logic [31:0] o_addr, o_wdata, o_cnt;

    assign o_ready = sel ? b_ready : a_ready;
    assign o_wr_en = sel ? b_wr_en : a_wr_en;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_full  = sel ? b_full  : a_full;
    assign o_ill   = sel ? b_ill   : a_ill;
    assign o_rng   = sel ? b_rng   : a_rng;
    assign o_addr  = sel ? 32'(b_addr) : 32'(a_addr);
    assign o_cnt   = sel ? 32'(b_cnt)  : 32'(a_cnt);
    assign o_wdata = sel ? b_wdata : a_wdata;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(a_ready), .in_type(in_type), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .mem_wr_en(a_wr_en), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_wr_ready(mem_wr_ready), .busy(a_busy), .full(a_full),
        .instr_count(a_cnt), .err_illegal(a_ill), .err_range(a_rng)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(b_ready), .in_type(in_type), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .mem_wr_en(b_wr_en), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_wr_ready(mem_wr_ready), .busy(b_busy), .full(b_full),
        .instr_count(b_cnt), .err_illegal(b_ill), .err_range(b_rng)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"}, 32'(o_wr_en), 0);
        chk({tag, " addr"}, o_addr, 0);
        chk({tag, " wdata"}, o_wdata, 0);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " full"}, 32'(o_full), 0);
        chk({tag, " count"}, o_cnt, 0);
        chk({tag, " errs"}, {30'd0, o_ill, o_rng}, 0);
        chk({tag, " in_ready"}, 32'(o_ready), 0);
    endtask

    function automatic bundle_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [31:0] imm);
        bundle_t b;
        b.t = t; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = 0; b.imm = imm;
        return b;
    endfunction

    // Reference: place each spec field at its bit position with shifts/masks,
    // range limits as plain signed integer bounds.
    function automatic void model(input bundle_t b, output logic legal, output logic ok,
                                  output logic [31:0] w);
        logic [31:0] imm, op, rd, rs1, rs2, f3, f7, regs;
        int s;
        imm = b.imm; op = 32'(b.op); rd = 32'(b.rd); rs1 = 32'(b.rs1); rs2 = 32'(b.rs2);
        f3 = 32'(b.f3); f7 = 32'(b.f7); s = $signed(b.imm);
        regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
        legal = 1; ok = 1; w = 0;
        case (b.t)
            3'd0: w = (f7 << 25) | regs | (rd << 7) | op;
            3'd1: if (b.op == OP_IMM && (b.f3 == 1 || b.f3 == 5)) begin
                ok = s >= 0 && s <= 31;
                w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end else begin
                ok = s >= -2048 && s <= 2047;
                w = ((imm & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3'd2: begin
                ok = s >= -2048 && s <= 2047;
                w = (((imm >> 5) & 127) << 25) | regs | ((imm & 31) << 7) | op;
            end
            3'd3: begin
                ok = s >= -4096 && s <= 4095 && s % 2 == 0;
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | regs
                  | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
            end
            3'd4: begin
                ok = (imm & 32'hfff) == 0;
                w = (imm & 32'hfffff000) | (rd << 7) | op;
            end
            3'd5: begin
                ok = s >= -(1 << 20) && s < (1 << 20) && s % 2 == 0;
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
            end
            default: legal = 0;
        endcase
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        int r;
        b.t = 3'($urandom_range(0, 7));
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        r = int'($urandom_range(0, 2));
        case (b.t)
            3'd0: b.op = OP;
            3'd1: b.op = r == 0 ? OP_IMM : r == 1 ? LOAD : JALR;
            3'd2: b.op = STORE;
            3'd3: b.op = BRANCH;
            3'd4: b.op = r == 0 ? LUI : AUIPC;
            3'd5: b.op = JAL;
            default: b.op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: b.imm = 32'(int'($urandom_range(0, 80)) - 40);
            1: b.imm = 32'(int'($urandom_range(0, 8400)) - 4200);
            2: b.imm = 32'(int'($urandom_range(0, 1 << 22)) - (1 << 21));
            default: b.imm = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) b.imm[0] = 1'b0;
        if (b.t == 3'd4 && $urandom_range(0, 1) == 1) b.imm[11:0] = '0;
        return b;
    endfunction

    task automatic pulse_start();
        start = 1; @(negedge clk); start = 0; #1;
    endtask

    task automatic pulse_finish();
        finish = 1; @(negedge clk); finish = 0; #1;
    endtask

    task automatic drive(input bundle_t b);
        in_type = b.t; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
    endtask

    // Present one bundle, then complete any resulting write after `stall` idle
    // cycles of mem_wr_ready, optionally pulsing finish at stall step fin_at.
    task automatic send(input bundle_t b, input int stall, input int fin_at,
                        output logic wrote, output logic [31:0] addr, output logic [31:0] word);
        int n = 0;
        wrote = 0; addr = 0; word = 0;
        drive(b);
        in_valid = 1;
        #1;
        while (!o_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("accept", 32'(o_ready), 1);
        if (!o_ready) begin in_valid = 0; return; end
        @(negedge clk);
        in_valid = 0;
        #1;
        wrote = o_wr_en;
        if (!wrote) return;
        addr = o_addr; word = o_wdata;
        for (int i = 0; i < stall; i++) begin
            if (i == fin_at) finish = 1;
            @(negedge clk);
            finish = 0;
            #1;
            chk("stall wr_en", 32'(o_wr_en), 1);
            chk("stall addr", o_addr, addr);
            chk("stall wdata", o_wdata, word);
            chk("stall in_ready", 32'(o_ready), 0);
        end
        mem_wr_ready = 1;
        @(negedge clk);
        mem_wr_ready = 0;
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic wr, legal, ok;
        logic [31:0] ad, wd, ew;
        int ea, ec;
        logic eill, erng;
        bundle_t b;

        tbl[0] = '{mk(FMT_I, OP_IMM, 1, 0, 0, 0, 5), 1, 0, 32'h00500093, 0, 0, 1};
        tbl[1] = '{mk(FMT_S, STORE, 0, 1, 2, 2, 8), 1, 1, 32'h0020A423, 0, 0, 2};
        tbl[2] = '{mk(FMT_B, BRANCH, 0, 1, 2, 0, -4), 1, 2, 32'hFE208EE3, 0, 0, 3};
        tbl[3] = '{mk(FMT_U, LUI, 5, 0, 0, 0, 32'h12345000), 1, 3, 32'h123452B7, 0, 0, 4};
        tbl[4] = '{mk(FMT_J, JAL, 1, 0, 0, 0, 2048), 1, 4, 32'h001000EF, 0, 0, 5};
        tbl[5] = '{mk(FMT_B, BRANCH, 0, 1, 2, 0, 3), 0, 0, 0, 0, 1, 5};
        tbl[6] = '{mk(FMT_I, OP_IMM, 1, 1, 0, 1, 33), 0, 0, 0, 0, 1, 5};
        tbl[7] = '{mk(FMT_N, OP, 1, 1, 1, 0, 0), 0, 0, 0, 1, 1, 5};

        repeat (2) @(negedge clk);
        #1;
        sel = 0; #1; chk_zero("reset A");
        sel = 1; #1; chk_zero("reset B");
        sel = 0; #1;
        rst = 0;

        pulse_start();
        chk("busy after start", 32'(o_busy), 1);
        foreach (tbl[i]) begin
            send(tbl[i].b, 0, -1, wr, ad, wd);
            chk($sformatf("vec%0d wrote", i), 32'(wr), 32'(tbl[i].wr));
            if (tbl[i].wr) begin
                chk($sformatf("vec%0d addr", i), ad, tbl[i].addr);
                chk($sformatf("vec%0d wdata", i), wd, tbl[i].word);
            end
            chk($sformatf("vec%0d err_illegal", i), 32'(o_ill), 32'(tbl[i].ill));
            chk($sformatf("vec%0d err_range", i), 32'(o_rng), 32'(tbl[i].rng));
            chk($sformatf("vec%0d count", i), o_cnt, 32'(tbl[i].cnt));
        end

        pulse_start();
        chk("start in RUN keeps errs", {30'd0, o_ill, o_rng}, 3);
        chk("start in RUN keeps count", o_cnt, 5);
        pulse_finish();
        chk("finish -> idle", 32'(o_busy), 0);
        pulse_start();
        chk("restart clears errs", {30'd0, o_ill, o_rng}, 0);
        chk("restart clears count", o_cnt, 0);

        send(tbl[0].b, 3, 1, wr, ad, wd);
        chk("stall write happened", 32'(wr), 1);
        chk("stall wdata", wd, 32'h00500093);
        chk("finish after write busy", 32'(o_busy), 0);
        chk("finish after write wr_en", 32'(o_wr_en), 0);
        chk("finish after write count", o_cnt, 1);

        pulse_start();
        ea = 0; ec = 0; eill = 0; erng = 0;
        for (int k = 0; k < 150; k++) begin
            b = rand_bundle();
            model(b, legal, ok, ew);
            send(b, int'($urandom_range(0, 2)), -1, wr, ad, wd);
            chk("rnd wrote", 32'(wr), 32'(legal && ok));
            if (legal && ok) begin
                chk("rnd addr", ad, 32'(ea % 256));
                chk("rnd wdata", wd, ew);
                ea++; ec++;
            end else if (!legal) eill = 1;
            else erng = 1;
            chk("rnd errs", {30'd0, o_ill, o_rng}, {30'd0, eill, erng});
            chk("rnd count", o_cnt, 32'(ec));
        end

        sel = 1;
        rst = 1;
        @(negedge clk);
        #1;
        chk_zero("reset B again");
        rst = 0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send(mk(FMT_I, OP_IMM, 5'(k), 0, 0, 0, k), 0, -1, wr, ad, wd);
            chk("small wrote", 32'(wr), 1);
            chk("small addr", ad, 32'((2 + k) % 4));
        end
        chk("small full", 32'(o_full), 1);
        chk("small count", o_cnt, 4);
        drive(tbl[0].b);
        in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("full in_ready", 32'(o_ready), 0);
            chk("full no write", 32'(o_wr_en), 0);
        end
        in_valid = 0;
        pulse_finish();
        pulse_start();
        chk("restart not full", 32'(o_full), 0);
        drive(tbl[3].b);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("small write pending", 32'(o_wr_en), 1);
        chk("small write addr", o_addr, 2);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk_zero("async reset mid-write");
        @(negedge clk);
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
